// File: rtl/fetch_controller_pkg.sv
// ---------------------------------------------------------------------------
// fetch_controller_pkg
//   Shared definitions for the instruction-fetch front end.
//   - fetch_state_t : FSM state encoding (FETCH, HOLD, DRAIN)
//   - NOP_INSTR     : encoding the IF/ID register loads on a flush
//   - pcAdvance     : helper that advances a PC by a step, wrapping silently
// ---------------------------------------------------------------------------
package fetch_controller_pkg;

  // FETCH : a request is on the bus and its data is delivered when it arrives
  // HOLD  : a fetched instruction is parked in the buffer while ID is stalled
  // DRAIN : a redirect arrived while a fetch was outstanding; its data is dropped
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'hF000_0000;

  // Overflow past the top of the address space is intentionally discarded.
  function automatic logic [31:0] pcAdvance(input logic [31:0] pc, input logic [31:0] step);
    return pc + step;
  endfunction

endpackage

// File: rtl/fetch_controller.sv
// ---------------------------------------------------------------------------
// fetch_controller
//   Owns the program counter, drives the instruction-memory request
//   handshake and produces pc / instruction / freeze / flush for the IF/ID
//   pipeline register. Redirect sources are resolved with a fixed priority:
//   branch redirect, then hazard stall, then memory wait.
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   asynchronous reset, active-high
//   i_hazard       in   hazard stall request (hold ID contents)
//   i_branch_taken in   redirect request from EX (one-cycle pulse)
//   i_branch_addr  in   redirect target, valid with i_branch_taken
//   i_imem_rdy     in   memory returns i_imem_rdata this cycle
//   i_imem_rdata   in   fetched instruction
//   o_imem_req     out  fetch request active
//   o_imem_addr    out  fetch address, stable while request waits
//   o_if_pc        out  pc + PC_STEP of the delivered instruction
//   o_if_instr     out  delivered instruction
//   o_if_freeze    out  IF/ID register hold
//   o_if_flush     out  IF/ID register loads NOP (only when not frozen)
// ---------------------------------------------------------------------------
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_hazard,
  input  logic              i_branch_taken,
  input  logic [ADDR_W-1:0] i_branch_addr,
  input  logic              i_imem_rdy,
  input  logic [DATA_W-1:0] i_imem_rdata,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [ADDR_W-1:0] o_if_pc,
  output logic [DATA_W-1:0] o_if_instr,
  output logic              o_if_freeze,
  output logic              o_if_flush
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_buf;
  logic [ADDR_W-1:0] r_target;

  logic [ADDR_W-1:0] w_pcInc;
  logic [ADDR_W-1:0] w_resetPcInc;

  assign w_pcInc      = r_pc + STEP;
  assign w_resetPcInc = RESET_PC + STEP;

  // Output decode. Everything here is consumed by the IF/ID register on the
  // same edge that updates our own state, so it must be combinational.
  // A branch always wins: it flushes and unfreezes regardless of hazard or
  // memory wait. While reset is held the outputs are forced to the boot fetch
  // so the first request is already on the bus when reset releases.
  always_comb begin
    o_imem_req  = 1'b1;
    o_imem_addr = r_pc;
    o_if_pc     = w_pcInc;
    o_if_instr  = i_imem_rdata;
    o_if_freeze = 1'b0;
    o_if_flush  = 1'b0;

    case (r_state)
      FETCH: begin
        if (i_branch_taken) begin
          o_if_flush = 1'b1;
        end else if (!i_imem_rdy || i_hazard) begin
          o_if_freeze = 1'b1;
        end
      end
      HOLD: begin
        o_imem_req = 1'b0;
        o_if_instr = r_buf;
        if (i_branch_taken) begin
          o_if_flush = 1'b1;
        end else if (i_hazard) begin
          o_if_freeze = 1'b1;
        end
      end
      DRAIN: begin
        // The IF/ID register already holds the NOP from the original flush;
        // only a fresh redirect needs to flush again.
        if (i_branch_taken) begin
          o_if_flush = 1'b1;
        end else begin
          o_if_freeze = 1'b1;
        end
      end
      default: begin
        o_if_freeze = 1'b1;
      end
    endcase

    if (rst) begin
      o_imem_req  = 1'b1;
      o_imem_addr = RESET_PC;
      o_if_pc     = w_resetPcInc;
      o_if_instr  = i_imem_rdata;
      o_if_freeze = ~i_imem_rdy;
      o_if_flush  = 1'b0;
    end
  end

  // State and datapath update. The PC only moves when an instruction is
  // actually handed to ID or a redirect is taken, which keeps o_imem_addr
  // stable for the whole life of an outstanding request. A redirect that
  // lands while a fetch is outstanding parks its target until the memory
  // answers, so the stale response is swallowed rather than delivered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= FETCH;
      r_pc     <= RESET_PC;
      r_buf    <= '0;
      r_target <= '0;
    end else begin
      case (r_state)
        FETCH: begin
          if (i_branch_taken) begin
            if (i_imem_rdy) begin
              r_pc <= i_branch_addr;
            end else begin
              r_target <= i_branch_addr;
              r_state  <= DRAIN;
            end
          end else if (i_imem_rdy) begin
            if (i_hazard) begin
              r_buf   <= i_imem_rdata;
              r_state <= HOLD;
            end else begin
              r_pc <= w_pcInc;
            end
          end
        end
        HOLD: begin
          if (i_branch_taken) begin
            r_pc    <= i_branch_addr;
            r_state <= FETCH;
          end else if (!i_hazard) begin
            r_pc    <= w_pcInc;
            r_state <= FETCH;
          end
        end
        DRAIN: begin
          if (i_branch_taken) begin
            r_target <= i_branch_addr;
          end
          if (i_imem_rdy) begin
            r_pc    <= i_branch_taken ? i_branch_addr : r_target;
            r_state <= FETCH;
          end
        end
        default: begin
          r_state <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// ---------------------------------------------------------------------------
// tb_fetch_controller
//   Directed bench for fetch_controller. The bench plays the instruction
//   memory itself: each step drives the handshake inputs for one cycle and
//   queues the outputs expected for that cycle; the outputs are sampled 1ns
//   after the falling edge and compared against the head of the queue.
// ---------------------------------------------------------------------------
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hazard = 1'b0;
  logic        branchTaken = 1'b0;
  logic [31:0] branchAddr = '0;
  logic        imemRdy = 1'b1;
  logic [31:0] imemRdata = '0;

  logic        imemReq;
  logic [31:0] imemAddr;
  logic [31:0] ifPc;
  logic [31:0] ifInstr;
  logic        ifFreeze;
  logic        ifFlush;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    string       tag;
    logic        req;
    logic [31:0] addr;
    logic [31:0] ifPc;
    logic [31:0] instr;
    logic        freeze;
    logic        flush;
    bit          chkInstr;
  } expT;

  expT expQ[$];

  fetch_controller #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .RESET_PC(32'h0),
    .PC_STEP (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_hazard      (hazard),
    .i_branch_taken(branchTaken),
    .i_branch_addr (branchAddr),
    .i_imem_rdy    (imemRdy),
    .i_imem_rdata  (imemRdata),
    .o_imem_req    (imemReq),
    .o_imem_addr   (imemAddr),
    .o_if_pc       (ifPc),
    .o_if_instr    (ifInstr),
    .o_if_freeze   (ifFreeze),
    .o_if_flush    (ifFlush)
  );

  // Free-running 10ns clock.
  always #5 clk = ~clk;

  // Safety net so a stuck run still ends with a report.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout compared=%0d mismatched=%0d", compared, mismatched);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cmpField(input string tag, input string field,
                          input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s.%s observed=0x%08h expected=0x%08h", tag, field, obs, exp);
    end
  endtask

  // Drive one cycle of inputs and queue what the outputs must be this cycle.
  task automatic applyStimulus(input logic rstV, input logic hz, input logic br,
                               input logic [31:0] ba, input logic rdy,
                               input logic [31:0] rd, input expT e);
    rst         = rstV;
    hazard      = hz;
    branchTaken = br;
    branchAddr  = ba;
    imemRdy     = rdy;
    imemRdata   = rd;
    expQ.push_back(e);
  endtask

  // Pop the oldest expectation and compare it with the live outputs.
  task automatic checkOutput();
    expT e;
    if (expQ.size() == 0) begin
      compared++;
      mismatched++;
      $error("[TB] FAIL scoreboard observed=empty expected=entry");
    end else begin
      e = expQ.pop_front();
      cmpField(e.tag, "req", 32'(imemReq), 32'(e.req));
      cmpField(e.tag, "addr", imemAddr, e.addr);
      cmpField(e.tag, "ifPc", ifPc, e.ifPc);
      cmpField(e.tag, "freeze", 32'(ifFreeze), 32'(e.freeze));
      cmpField(e.tag, "flush", 32'(ifFlush), 32'(e.flush));
      if (e.chkInstr) begin
        cmpField(e.tag, "instr", ifInstr, e.instr);
      end
    end
  endtask

  task automatic step(input string tag, input logic hz, input logic br,
                      input logic [31:0] ba, input logic rdy, input logic [31:0] rd,
                      input logic eReq, input logic [31:0] eAddr, input logic [31:0] eIfPc,
                      input logic [31:0] eInstr, input logic eFr, input logic eFl);
    expT e;
    e.tag = tag; e.req = eReq; e.addr = eAddr; e.ifPc = eIfPc;
    e.instr = eInstr; e.freeze = eFr; e.flush = eFl; e.chkInstr = 1'b1;
    applyStimulus(1'b0, hz, br, ba, rdy, rd, e);
    #1;
    checkOutput();
    @(negedge clk);
  endtask

  // Reset is asserted on a falling edge, so it also covers mid-transaction
  // reset: the outputs must snap to the boot fetch within the same cycle.
  task automatic resetDut(input string tag, input logic rdy);
    expT e;
    e.tag = tag; e.req = 1'b1; e.addr = 32'h0; e.ifPc = 32'h4;
    e.instr = 32'h0; e.freeze = ~rdy; e.flush = 1'b0; e.chkInstr = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, rdy, 32'h0, e);
    #1;
    checkOutput();
    @(negedge clk);
  endtask

  initial begin
    $display("[TB] fetch_controller bench start");
    @(negedge clk);

    // Reset state, with and without a ready memory.
    resetDut("rstNoRdy", 1'b0);
    resetDut("rstRdy", 1'b1);

    // Zero-wait memory: one instruction per cycle.
    for (int i = 0; i < 4; i++) begin
      step("zeroWait", 0, 0, 32'h0, 1, 32'hA000_0000 + 32'(i),
           1, 32'(i * 4), 32'(i * 4 + 4), 32'hA000_0000 + 32'(i), 0, 0);
    end

    // Memory wait at pc=8 for three cycles.
    resetDut("rstWait", 1'b1);
    step("waitPre0", 0, 0, 32'h0, 1, 32'h0000_1000, 1, 32'h0, 32'h4, 32'h0000_1000, 0, 0);
    step("waitPre1", 0, 0, 32'h0, 1, 32'h0000_1004, 1, 32'h4, 32'h8, 32'h0000_1004, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step("memWait", 0, 0, 32'h0, 0, 32'h0, 1, 32'h8, 32'hC, 32'h0, 1, 0);
    end
    step("waitDone", 0, 0, 32'h0, 1, 32'hCAFE_0008, 1, 32'h8, 32'hC, 32'hCAFE_0008, 0, 0);
    step("waitNext", 0, 0, 32'h0, 1, 32'h0000_1234, 1, 32'hC, 32'h10, 32'h0000_1234, 0, 0);

    // Hazard stall while the instruction at pc=4 returns, then HOLD-branch.
    resetDut("rstHaz", 1'b1);
    step("hazPre", 0, 0, 32'h0, 1, 32'h0000_0100, 1, 32'h0, 32'h4, 32'h0000_0100, 0, 0);
    step("hazCapture", 1, 0, 32'h0, 1, 32'hE3A0_1005, 1, 32'h4, 32'h8, 32'hE3A0_1005, 1, 0);
    step("hazHold", 1, 0, 32'h0, 0, 32'h0, 0, 32'h4, 32'h8, 32'hE3A0_1005, 1, 0);
    step("hazRelease", 0, 0, 32'h0, 0, 32'h0, 0, 32'h4, 32'h8, 32'hE3A0_1005, 0, 0);
    step("hazResume", 0, 0, 32'h0, 1, 32'h0000_5555, 1, 32'h8, 32'hC, 32'h0000_5555, 0, 0);
    step("holdEnter", 1, 0, 32'h0, 1, 32'h0000_6666, 1, 32'hC, 32'h10, 32'h0000_6666, 1, 0);
    step("holdBranch", 1, 1, 32'h60, 0, 32'h0, 0, 32'hC, 32'h10, 32'h0000_6666, 0, 1);
    step("holdTarget", 0, 0, 32'h0, 1, 32'h0000_7777, 1, 32'h60, 32'h64, 32'h0000_7777, 0, 0);

    // Branch with ready memory and a simultaneous hazard, then PC wrap.
    resetDut("rstBr", 1'b1);
    step("brPre", 0, 0, 32'h0, 1, 32'h0000_0200, 1, 32'h0, 32'h4, 32'h0000_0200, 0, 0);
    step("brHaz", 1, 1, 32'h100, 1, 32'h0000_0BAD, 1, 32'h4, 32'h8, 32'h0000_0BAD, 0, 1);
    step("brTarget", 0, 0, 32'h0, 1, 32'h0000_8888, 1, 32'h100, 32'h104, 32'h0000_8888, 0, 0);
    step("brToTop", 0, 1, 32'hFFFF_FFFC, 1, 32'h0000_0001, 1, 32'h104, 32'h108, 32'h0000_0001, 0, 1);
    step("wrapTop", 0, 0, 32'h0, 1, 32'h0000_9999, 1, 32'hFFFF_FFFC, 32'h0, 32'h0000_9999, 0, 0);
    step("wrapZero", 0, 0, 32'h0, 1, 32'h0000_9998, 1, 32'h0, 32'h4, 32'h0000_9998, 0, 0);

    // Branch while a fetch at 0x20 is outstanding: drain and drop its data.
    resetDut("rstDrain", 1'b1);
    step("toX20", 0, 1, 32'h20, 1, 32'h0, 1, 32'h0, 32'h4, 32'h0, 0, 1);
    step("x20Wait", 0, 0, 32'h0, 0, 32'h0, 1, 32'h20, 32'h24, 32'h0, 1, 0);
    step("drainEnter", 0, 1, 32'h200, 0, 32'h0, 1, 32'h20, 32'h24, 32'h0, 0, 1);
    step("drainWait0", 0, 0, 32'h0, 0, 32'h0, 1, 32'h20, 32'h24, 32'h0, 1, 0);
    step("drainWait1", 1, 0, 32'h0, 0, 32'h0, 1, 32'h20, 32'h24, 32'h0, 1, 0);
    step("drainDrop", 0, 0, 32'h0, 1, 32'hDEAD_0020, 1, 32'h20, 32'h24, 32'hDEAD_0020, 1, 0);
    step("drainTarget", 0, 0, 32'h0, 1, 32'h0000_AAAA, 1, 32'h200, 32'h204, 32'h0000_AAAA, 0, 0);

    // Repeated redirects during DRAIN: the latest target wins.
    resetDut("rstLatest", 1'b1);
    step("latest0", 0, 1, 32'h40, 0, 32'h0, 1, 32'h0, 32'h4, 32'h0, 0, 1);
    step("latest1", 0, 1, 32'h80, 0, 32'h0, 1, 32'h0, 32'h4, 32'h0, 0, 1);
    step("latestDrop", 0, 0, 32'h0, 1, 32'hDEAD_0000, 1, 32'h0, 32'h4, 32'hDEAD_0000, 1, 0);
    step("latestTarget", 0, 0, 32'h0, 1, 32'h0000_B0B0, 1, 32'h80, 32'h84, 32'h0000_B0B0, 0, 0);

    // Reset asserted while draining.
    step("midDrain0", 0, 1, 32'h400, 0, 32'h0, 1, 32'h84, 32'h88, 32'h0, 0, 1);
    step("midDrain1", 0, 0, 32'h0, 0, 32'h0, 1, 32'h84, 32'h88, 32'h0, 1, 0);
    resetDut("rstMidDrain", 1'b0);
    step("afterRst", 0, 0, 32'h0, 1, 32'h0000_C0C0, 1, 32'h0, 32'h4, 32'h0000_C0C0, 0, 0);

    if (expQ.size() != 0) begin
      compared++;
      mismatched++;
      $error("[TB] FAIL scoreboardLeft observed=%0d expected=0", expQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
Sequences the instruction-fetch front end. Owns the program counter and drives the instruction-memory request handshake. Produces pc/instruction/freeze/flush for the IF/ID pipeline register. Resolves three stall/redirect sources each cycle with a fixed priority: branch redirect, then hazard stall, then memory wait.

Parameters:
ADDR_W, 32, width of PC, branch target and memory address
DATA_W, 32, instruction width
RESET_PC, 0, PC value loaded on reset
PC_STEP, 4, PC increment per delivered instruction

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
hazard  in  1  stall request from hazard detection (hold ID contents)
branch_taken  in  1  redirect request from EX stage, one-cycle pulse
branch_addr  in  ADDR_W  redirect target, valid with branch_taken
imem_rdy  in  1  memory returns imem_rdata this cycle (may be same cycle as request)
imem_rdata  in  DATA_W  fetched instruction
imem_req  out  1  fetch request active
imem_addr  out  ADDR_W  fetch address, stable while imem_req=1 until imem_rdy=1
if_pc  out  ADDR_W  pc+PC_STEP of delivered instruction (to IF reg pc_in)
if_instr  out  DATA_W  delivered instruction (to IF reg instruction_in)
if_freeze  out  1  IF reg hold
if_flush  out  1  IF reg load NOP (effective only when if_freeze=0)

Behaviour:
- Registers: state {FETCH, HOLD, DRAIN}, pc, buf (DATA_W), target (ADDR_W).
- Reset (async): state=FETCH, pc=RESET_PC, buf=0, target=0.
- Outputs are combinational from state, registers and inputs. They are consumed by the IF reg on the same edge.
- Default outputs: imem_addr=pc, if_pc=pc+PC_STEP (mod 2^ADDR_W, wraps silently), if_flush=0.
- In reset: imem_req=1, imem_addr=RESET_PC, if_freeze=~imem_rdy.
- FETCH: imem_req=1, if_instr=imem_rdata.
  - branch_taken & imem_rdy: if_flush=1, if_freeze=0, data discarded, pc<=branch_addr, stay FETCH.
  - branch_taken & ~imem_rdy: if_flush=1, if_freeze=0, target<=branch_addr, go DRAIN (outstanding fetch must complete).
  - imem_rdy & ~hazard: if_freeze=0, pc<=pc+PC_STEP.
  - imem_rdy & hazard: if_freeze=1, buf<=imem_rdata, go HOLD, pc unchanged.
  - ~imem_rdy (no branch): if_freeze=1.
- HOLD: imem_req=0, if_instr=buf.
  - branch_taken: if_flush=1, if_freeze=0, pc<=branch_addr, go FETCH.
  - hazard: if_freeze=1.
  - else: if_freeze=0, pc<=pc+PC_STEP, go FETCH.
- DRAIN: imem_req=1, imem_addr=pc (old address held), if_instr=imem_rdata. The IF reg already holds the NOP.
  - branch_taken: if_flush=1, if_freeze=0, target<=branch_addr (latest wins).
  - else: if_freeze=1.
  - imem_rdy: data discarded, pc<=(branch_taken ? branch_addr : target), go FETCH.
- Priority: branch_taken > hazard > memory wait. hazard is ignored whenever branch_taken=1.
- Invariants:
  - if_flush=1 implies if_freeze=0.
  - No instruction is delivered twice or lost.
  - imem_addr never changes while imem_req=1 and imem_rdy=0.
- Reset mid-transaction: state returns to FETCH at RESET_PC and any in-flight memory response is not tracked. Memory must also be reset.

Decomposition:
- Shared package: state encoding constants (FETCH, HOLD, DRAIN) and NOP encoding 32'hF000_0000 for bench checks.
- No sub-module. A single FSM with a datapath is natural.

Test Plan:
- Zero-wait memory (imem_rdy=1 always), no hazard, 4 cycles after reset -> imem_addr 0,4,8,12; if_pc 4,8,12,16; if_freeze=0 throughout.
- imem_rdy low 3 cycles at pc=8 -> if_freeze=1 for 3 cycles, imem_addr held 8, then instruction delivered with if_pc=12.
- hazard high 2 cycles while rdata=32'hE3A01005 returned at pc=4 -> state HOLD, imem_req=0, if_freeze=1 for 2 cycles; next cycle if_instr=32'hE3A01005, if_pc=8, pc=8.
- branch_taken to 0x100 with rdy=1 and hazard=1 same cycle -> if_flush=1, if_freeze=0; next imem_addr=0x100.
- branch_taken to 0x200 while fetch at 0x20 pending (rdy=0 for 2 more cycles) -> DRAIN, imem_addr stays 0x20, returned data dropped; then imem_addr=0x200.
- Assert rst during DRAIN -> immediately pc=0, state FETCH, imem_addr=0, if_flush=0.
